// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared dev_ram operation and size codes
package ram_pkg;

  localparam int RAM_OP_BITS   = 2;
  localparam int RAM_SIZE_BITS = 2;

  typedef enum logic [RAM_OP_BITS-1:0] {
    RAM_NOP   = 2'd0,
    RAM_READ  = 2'd1,
    RAM_WRITE = 2'd2
  } ram_op_t;

  typedef enum logic [RAM_SIZE_BITS-1:0] {
    SIZE_BYTE  = 2'd0,
    SIZE_HALF  = 2'd1,
    SIZE_WORD  = 2'd2,
    SIZE_DWORD = 2'd3
  } ram_size_t;

  // Index width for a port count; a single port still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - cyclic first-one finder starting at a given pointer
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int               pos;
  logic [IDX_W-1:0] pos_i;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    pos_i = '0;
    for (int k = 0; k < N; k++) begin
      // start is always < N, so one subtraction is enough to wrap
      pos = int'(start) + k;
      if (pos >= N) pos = pos - N;
      pos_i = IDX_W'(pos);
      if (!any && req[pos_i]) begin
        gnt[pos_i] = 1'b1;
        idx        = pos_i;
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dev_ram_arbiter.sv
// rtl/dev_ram_arbiter.sv - N-master request/grant arbiter in front of the single-ported dev_ram
module dev_ram_arbiter
  import ram_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int PRIO_MODE = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_PORTS-1:0]               m_req,
  input  logic [NUM_PORTS-1:0]               m_lock,
  input  logic [NUM_PORTS*RAM_OP_BITS-1:0]   m_op,
  input  logic [NUM_PORTS*RAM_SIZE_BITS-1:0] m_size,
  input  logic [NUM_PORTS*ADDR_W-1:0]        m_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]        m_wdata,
  output logic [NUM_PORTS-1:0]               m_gnt,
  output logic [NUM_PORTS-1:0]               m_rvalid,
  output logic [DATA_W-1:0]                  m_rdata,
  output ram_op_t                            ram_op,
  output logic [RAM_SIZE_BITS-1:0]           ram_size,
  output logic [ADDR_W-1:0]                  ram_addr,
  output logic [DATA_W-1:0]                  ram_data_in,
  input  logic [DATA_W-1:0]                  ram_data_out
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  logic [RAM_OP_BITS-1:0]   op_a   [NUM_PORTS];
  logic [RAM_SIZE_BITS-1:0] size_a [NUM_PORTS];
  logic [ADDR_W-1:0]        addr_a [NUM_PORTS];
  logic [DATA_W-1:0]        wdata_a[NUM_PORTS];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign op_a[g]    = m_op[g*RAM_OP_BITS +: RAM_OP_BITS];
    assign size_a[g]  = m_size[g*RAM_SIZE_BITS +: RAM_SIZE_BITS];
    assign addr_a[g]  = m_addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = m_wdata[g*DATA_W +: DATA_W];
  end

  logic                 ready_q;
  logic                 lock_valid;
  logic [IDX_W-1:0]     lock_owner;
  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_PORTS-1:0] rvalid_q;

  logic [NUM_PORTS-1:0] owner_mask;
  logic [NUM_PORTS-1:0] eligible;
  logic [IDX_W-1:0]     pick_start;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;

  logic [NUM_PORTS-1:0] rvalid_d;
  logic [IDX_W-1:0]     ptr_next;

  // Nothing is granted in the first cycle after reset release; while locked
  // only the owner is eligible.
  always_comb begin
    owner_mask             = '0;
    owner_mask[lock_owner] = 1'b1;
    if (!ready_q)        eligible = '0;
    else if (lock_valid) eligible = m_req & owner_mask;
    else                 eligible = m_req;
  end

  assign pick_start = (PRIO_MODE == 1) ? rr_ptr : '0;

  rr_pick #(
    .N    (NUM_PORTS),
    .IDX_W(IDX_W)
  ) u_pick (
    .req  (eligible),
    .start(pick_start),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign m_gnt    = pick_gnt;
  assign m_rvalid = rvalid_q;
  assign m_rdata  = ram_data_out;

  always_comb begin
    ram_op      = RAM_NOP;
    ram_size    = '0;
    ram_addr    = '0;
    ram_data_in = '0;
    if (pick_any) begin
      ram_op      = ram_op_t'(op_a[pick_idx]);
      ram_size    = size_a[pick_idx];
      ram_addr    = addr_a[pick_idx];
      ram_data_in = wdata_a[pick_idx];
    end
  end

  always_comb begin
    rvalid_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rvalid_d[i] = pick_gnt[i] && (op_a[i] == RAM_READ);
    end
    ptr_next = (pick_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : pick_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      rr_ptr     <= '0;
      rvalid_q   <= '0;
    end else begin
      ready_q  <= 1'b1;
      rvalid_q <= rvalid_d;
      if (pick_any) begin
        rr_ptr     <= ptr_next;
        lock_valid <= m_lock[pick_idx];
        lock_owner <= pick_idx;
      end else if (lock_valid && !m_req[lock_owner] && !m_lock[lock_owner]) begin
        // Owner gave up the bus without issuing a final access.
        lock_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dev_ram_arbiter.sv
// tb/tb_dev_ram_arbiter.sv - self-checking bench for dev_ram_arbiter in three configurations
module tb_dev_ram_arbiter;
  import ram_pkg::*;

  localparam int NI   = 3;
  localparam int MAXP = 5;
  localparam int AW   = 32;
  localparam int DW   = 64;
  localparam logic [1:0] OP_N = 2'd0;
  localparam logic [1:0] OP_R = 2'd1;
  localparam logic [1:0] OP_W = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [MAXP-1:0]    req   [NI];
  logic [MAXP-1:0]    lck   [NI];
  logic [2*MAXP-1:0]  op    [NI];
  logic [2*MAXP-1:0]  sz    [NI];
  logic [MAXP*AW-1:0] addr  [NI];
  logic [MAXP*DW-1:0] wd    [NI];
  logic [MAXP-1:0]    gnt   [NI];
  logic [MAXP-1:0]    rvalid[NI];
  logic [DW-1:0]      rdata [NI];
  logic [1:0]         rop   [NI];
  logic [1:0]         rsz   [NI];
  logic [AW-1:0]      raddr [NI];
  logic [DW-1:0]      rdin  [NI];

  // Instance 0: 2 ports fixed priority; 1: 3 ports RR; 2: 5 ports RR.
  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int NP = (k == 0) ? 2 : (k == 1) ? 3 : 5;
    localparam int PM = (k == 0) ? 0 : 1;
    logic [NP-1:0] g, rv;
    logic [DW-1:0] rd;
    logic [DW-1:0] dout = '0;
    ram_op_t       o;
    logic [1:0]    s;
    logic [AW-1:0] a;
    logic [DW-1:0] di;
    logic [DW-1:0] mem [128] = '{default: '0};

    dev_ram_arbiter #(
      .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(PM)
    ) u_arb (
      .clk(clk), .rst_n(rst_n),
      .m_req(req[k][NP-1:0]), .m_lock(lck[k][NP-1:0]),
      .m_op(op[k][2*NP-1:0]), .m_size(sz[k][2*NP-1:0]),
      .m_addr(addr[k][NP*AW-1:0]), .m_wdata(wd[k][NP*DW-1:0]),
      .m_gnt(g), .m_rvalid(rv), .m_rdata(rd),
      .ram_op(o), .ram_size(s), .ram_addr(a), .ram_data_in(di),
      .ram_data_out(dout)
    );

    always @(posedge clk) begin
      if (o == RAM_WRITE) mem[a[6:0]] <= di;
      if (o == RAM_READ)  dout <= mem[a[6:0]];
    end

    assign gnt[k]    = MAXP'(g);
    assign rvalid[k] = MAXP'(rv);
    assign rdata[k]  = rd;
    assign rop[k]    = o;
    assign rsz[k]    = s;
    assign raddr[k]  = a;
    assign rdin[k]   = di;
  end

  function automatic int np(input int k);
    return (k == 0) ? 2 : (k == 1) ? 3 : 5;
  endfunction

  function automatic int dut_ptr(input int k);
    case (k)
      0:       return int'(g_dut[0].u_arb.rr_ptr);
      1:       return int'(g_dut[1].u_arb.rr_ptr);
      default: return int'(g_dut[2].u_arb.rr_ptr);
    endcase
  endfunction

  function automatic int dut_lock(input int k);
    case (k)
      0:       return int'(g_dut[0].u_arb.lock_valid);
      1:       return int'(g_dut[1].u_arb.lock_valid);
      default: return int'(g_dut[2].u_arb.lock_valid);
    endcase
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/pointer/pending read per instance plus a shadow memory.
  int            m_ptr   [NI];
  int            m_owner [NI];
  int            m_pend  [NI];
  bit            m_locked[NI];
  bit            m_ready [NI];
  logic [DW-1:0] m_pdata [NI];
  logic [DW-1:0] m_mem   [NI][128];

  function automatic int model_pick(input int k);
    int n, start, p;
    n = np(k);
    if (!m_ready[k]) return -1;
    if (m_locked[k]) return req[k][m_owner[k]] ? m_owner[k] : -1;
    start = (k == 0) ? 0 : m_ptr[k];
    for (int j = 0; j < n; j++) begin
      p = (start + j) % n;
      if (req[k][p]) return p;
    end
    return -1;
  endfunction

  task automatic model_cycle();
    int eg;
    logic [1:0]    eop, esz;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        check($sformatf("i%0d reset gnt", k), gnt[k], 0);
        check($sformatf("i%0d reset rvalid", k), rvalid[k], 0);
        check($sformatf("i%0d reset ram_op", k), rop[k], 0);
        check($sformatf("i%0d reset rr_ptr", k), dut_ptr(k), 0);
        check($sformatf("i%0d reset lock", k), dut_lock(k), 0);
        m_ready[k] = 0; m_locked[k] = 0; m_ptr[k] = 0; m_pend[k] = -1; m_owner[k] = 0;
        continue;
      end
      eg  = model_pick(k);
      eop = 0; esz = 0; ea = 0; ed = 0;
      if (eg >= 0) begin
        eop = op[k][2*eg +: 2];
        esz = sz[k][2*eg +: 2];
        ea  = addr[k][AW*eg +: AW];
        ed  = wd[k][DW*eg +: DW];
      end
      check($sformatf("i%0d gnt", k), gnt[k], (eg >= 0) ? (1 << eg) : 0);
      check($sformatf("i%0d ram bus", k), {rop[k], rsz[k], raddr[k], rdin[k]}, {eop, esz, ea, ed});
      check($sformatf("i%0d rvalid", k), rvalid[k], (m_pend[k] >= 0) ? (1 << m_pend[k]) : 0);
      if (m_pend[k] >= 0) check($sformatf("i%0d rdata", k), rdata[k], m_pdata[k]);
      check($sformatf("i%0d rr_ptr", k), dut_ptr(k), m_ptr[k]);
      check($sformatf("i%0d lock", k), dut_lock(k), int'(m_locked[k]));
      m_pend[k] = -1;
      if (eg >= 0) begin
        if (eop == OP_R) begin
          m_pend[k]  = eg;
          m_pdata[k] = m_mem[k][ea[6:0]];
        end
        if (eop == OP_W) m_mem[k][ea[6:0]] = ed;
        m_ptr[k]    = (eg + 1) % np(k);
        m_locked[k] = lck[k][eg];
        m_owner[k]  = eg;
      end else if (m_locked[k] && !req[k][m_owner[k]] && !lck[k][m_owner[k]]) begin
        m_locked[k] = 0;
      end
      m_ready[k] = 1;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NI; k++) begin
      req[k] = '0; lck[k] = '0; op[k] = '0; sz[k] = '0; addr[k] = '0; wd[k] = '0;
    end
  endtask

  typedef struct {
    logic [1:0]  req, lck, op0, op1;
    logic [7:0]  a0, a1;
    logic [63:0] w0, w1;
    logic [1:0]  eg, erv, eop;
    logic [63:0] erd;
  } vec_t;

  vec_t tv [17];

  initial begin
    tv[0]  = '{2'b11, 2'b00, OP_R, OP_R, 8'h10, 8'h20, 64'h0, 64'h0, 2'b00, 2'b00, OP_N, 64'h0};
    tv[1]  = '{2'b11, 2'b00, OP_R, OP_R, 8'h10, 8'h20, 64'h0, 64'h0, 2'b01, 2'b00, OP_R, 64'h0};
    tv[2]  = '{2'b11, 2'b00, OP_R, OP_R, 8'h10, 8'h20, 64'h0, 64'h0, 2'b01, 2'b01, OP_R, 64'h0};
    tv[3]  = '{2'b11, 2'b00, OP_R, OP_R, 8'h10, 8'h20, 64'h0, 64'h0, 2'b01, 2'b01, OP_R, 64'h0};
    tv[4]  = '{2'b01, 2'b00, OP_W, OP_R, 8'h40, 8'h20, 64'hDEADBEEF, 64'h0, 2'b01, 2'b01, OP_W, 64'h0};
    tv[5]  = '{2'b10, 2'b00, OP_N, OP_R, 8'h00, 8'h40, 64'h0, 64'h0, 2'b10, 2'b00, OP_R, 64'h0};
    tv[6]  = '{2'b00, 2'b00, OP_N, OP_N, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b10, OP_N, 64'hDEADBEEF};
    tv[7]  = '{2'b10, 2'b10, OP_N, OP_W, 8'h00, 8'h08, 64'h0, 64'hAA, 2'b10, 2'b00, OP_W, 64'h0};
    tv[8]  = '{2'b01, 2'b10, OP_R, OP_N, 8'h10, 8'h00, 64'h0, 64'h0, 2'b00, 2'b00, OP_N, 64'h0};
    tv[9]  = '{2'b01, 2'b10, OP_R, OP_N, 8'h10, 8'h00, 64'h0, 64'h0, 2'b00, 2'b00, OP_N, 64'h0};
    tv[10] = '{2'b11, 2'b00, OP_R, OP_R, 8'h10, 8'h08, 64'h0, 64'h0, 2'b10, 2'b00, OP_R, 64'h0};
    tv[11] = '{2'b01, 2'b00, OP_R, OP_N, 8'h10, 8'h00, 64'h0, 64'h0, 2'b01, 2'b10, OP_R, 64'hAA};
    tv[12] = '{2'b00, 2'b00, OP_N, OP_N, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b01, OP_N, 64'h0};
    tv[13] = '{2'b10, 2'b10, OP_N, OP_N, 8'h00, 8'h00, 64'h0, 64'h0, 2'b10, 2'b00, OP_N, 64'h0};
    tv[14] = '{2'b01, 2'b00, OP_R, OP_N, 8'h10, 8'h00, 64'h0, 64'h0, 2'b00, 2'b00, OP_N, 64'h0};
    tv[15] = '{2'b01, 2'b00, OP_R, OP_N, 8'h10, 8'h00, 64'h0, 64'h0, 2'b01, 2'b00, OP_R, 64'h0};
    tv[16] = '{2'b00, 2'b00, OP_N, OP_N, 8'h00, 8'h00, 64'h0, 64'h0, 2'b00, 2'b01, OP_N, 64'h0};

    for (int k = 0; k < NI; k++)
      for (int i = 0; i < 128; i++) m_mem[k][i] = '0;
    clear_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      #1 model_cycle();
      @(negedge clk);
    end
    rst_n = 1'b1;

    // Directed table on the 2-port fixed-priority instance.
    for (int i = 0; i < 17; i++) begin
      clear_inputs();
      req[0]  = MAXP'(tv[i].req);
      lck[0]  = MAXP'(tv[i].lck);
      op[0]   = (2*MAXP)'({tv[i].op1, tv[i].op0});
      addr[0] = (MAXP*AW)'({32'(tv[i].a1), 32'(tv[i].a0)});
      wd[0]   = (MAXP*DW)'({tv[i].w1, tv[i].w0});
      #1;
      check($sformatf("vec%0d gnt", i), gnt[0], tv[i].eg);
      check($sformatf("vec%0d rvalid", i), rvalid[0], tv[i].erv);
      check($sformatf("vec%0d ram_op", i), rop[0], tv[i].eop);
      if (tv[i].erv != 0) check($sformatf("vec%0d rdata", i), rdata[0], tv[i].erd);
      model_cycle();
      @(negedge clk);
    end

    // Round-robin over three ports held requesting.
    for (int c = 0; c < 7; c++) begin
      clear_inputs();
      if (c < 6) begin
        req[1] = 5'b00111;
        op[1]  = 10'b00_0101_0101;
        addr[1] = (MAXP*AW)'({32'h22, 32'h21, 32'h20});
      end
      #1;
      if (c < 6) check($sformatf("rr3 gnt c%0d", c), gnt[1], 1 << (c % 3));
      check($sformatf("rr3 rvalid c%0d", c), rvalid[1], (c == 0) ? 0 : 1 << ((c - 1) % 3));
      model_cycle();
      @(negedge clk);
    end

    // Five ports: port 4 then port 0, pointer must wrap to 0.
    clear_inputs();
    req[2] = 5'b10000;
    #1 check("rr5 gnt p4", gnt[2], 5'b10000);
    model_cycle();
    @(negedge clk);
    clear_inputs();
    req[2] = 5'b00001;
    #1 check("rr5 ptr wrap", dut_ptr(2), 0);
    check("rr5 gnt p0", gnt[2], 5'b00001);
    model_cycle();
    @(negedge clk);

    // Locked read on instance 0, then reset before data returns.
    clear_inputs();
    req[0] = 5'b00001; lck[0] = 5'b00001; op[0] = 10'b01; addr[0] = (MAXP*AW)'(32'h10);
    #1 model_cycle();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #1 check("reset mid read rvalid", rvalid[0], 0);
    check("reset mid read lock", dut_lock(0), 0);
    model_cycle();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic on all instances against the model.
    for (int c = 0; c < 3000; c++) begin
      clear_inputs();
      for (int k = 0; k < NI; k++) begin
        for (int p = 0; p < np(k); p++) begin
          req[k][p] = ($urandom_range(0, 9) < 6);
          lck[k][p] = ($urandom_range(0, 9) < 2);
          op[k][2*p +: 2]   = 2'($urandom_range(0, 2));
          sz[k][2*p +: 2]   = 2'($urandom_range(0, 3));
          addr[k][AW*p +: AW] = AW'($urandom_range(0, 127));
          wd[k][DW*p +: DW] = {$urandom, $urandom};
        end
      end
      rst_n = ($urandom_range(0, 499) != 0);
      #1 model_cycle();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
